// File: rtl/zap_pkg.sv
// Shared definitions for the ZAP instruction prefetch path.
// Contents:
//   zap_pf_state_t  - prefetch controller states (IDLE, REQ, DRAIN)
//   ZAP_WORD_BYTES  - fetch stride in bytes (one 32-bit word)
//   ZAP_SEL_ALL     - Wishbone byte select covering a full word
//   zap_word_align  - clears the byte-offset bits of an address
package zap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } zap_pf_state_t;

  localparam logic [31:0] ZAP_WORD_BYTES = 32'd4;
  localparam logic [3:0]  ZAP_SEL_ALL    = 4'hF;

  function automatic logic [31:0] zap_word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/zap_prefetch_credit.sv
// Occupancy counter for the prefetch controller: FIFO entries plus
// outstanding fetches. Saturates at DEPTH and never underflows.
// Ports:
//   i_clk, i_reset   - clock, asynchronous active-high reset
//   i_inc            - a new request is being issued
//   i_dec            - the FIFO consumer popped one entry
//   i_load_en        - overwrite the count with i_load_val (wins over inc/dec)
//   i_load_val       - value to load
//   o_has_credit     - count < DEPTH, another request may be issued
module zap_prefetch_credit #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_load_en,
  input  logic [CW-1:0] i_load_val,
  output logic          o_has_credit
);

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic          w_dec_ok;

  // A pop against an empty count is meaningless and is dropped.
  assign w_dec_ok     = i_dec && (r_count != '0);
  assign o_has_credit = (r_count < LP_DEPTH);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load_en) begin
      r_count <= i_load_val;
    end else if (i_inc && !w_dec_ok && (r_count < LP_DEPTH)) begin
      r_count <= r_count + CW'(1);
    end else if (!i_inc && w_dec_ok) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/zap_prefetch_ctrl.sv
// Instruction prefetch controller: issues sequential Wishbone classic
// word reads while the downstream FIFO has room, and writes each response
// into the FIFO. A flush redirects fetch; a response already in flight is
// drained and discarded.
// Ports:
//   i_clk, i_reset              - clock, asynchronous active-high reset
//   i_flush, i_flush_pc         - redirect request and new fetch address
//   i_fifo_pop                  - consumer removed one FIFO entry
//   o_wb_stb/cyc/adr/sel/we     - Wishbone read request
//   i_wb_ack, i_wb_err, i_wb_dat- Wishbone completion, error, read data
//   o_valid, o_instr, o_pc, o_abort - FIFO write port (one-cycle strobe)
//   o_discard_cnt               - saturating count of dropped responses,
//                                 present only with ZAP_PREFETCH_PERF_EN
module zap_prefetch_ctrl #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_fifo_pop,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_abort
`ifdef ZAP_PREFETCH_PERF_EN
  ,
  output logic [15:0] o_discard_cnt
`endif
);

  import zap_pkg::*;

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LP_ONE = CW'(1);
  localparam logic [31:0] LP_RST_PC = zap_word_align(RESET_VECTOR);

  zap_pf_state_t r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_drain_adr, w_drain_adr_nxt;
  logic          w_ack_any;
  logic          w_inc;
  logic          w_load_en;
  logic          w_has_credit;
  logic          w_rsp_take;
  logic          w_discard;

  logic          r_valid;
  logic [31:0]   r_instr;
  logic [31:0]   r_opc;
  logic          r_abort;

  assign w_ack_any = i_wb_ack | i_wb_err;

  zap_prefetch_credit #(
    .DEPTH (DEPTH)
  ) u_credit (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inc        (w_inc),
    .i_dec        (i_fifo_pop),
    .i_load_en    (w_load_en),
    .i_load_val   (LP_ONE),
    .o_has_credit (w_has_credit)
  );

  // Every flush reloads occupancy to 1: the FIFO is invalidated and the
  // only thing left to account for is the request about to be issued at
  // the new pc (a drained response never reaches the FIFO).
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drain_adr_nxt = r_drain_adr;
    w_inc           = 1'b0;
    w_load_en       = 1'b0;
    w_rsp_take      = 1'b0;
    w_discard       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_flush) begin
          w_pc_nxt    = zap_word_align(i_flush_pc);
          w_load_en   = 1'b1;
          w_state_nxt = REQ;
        end else if (w_has_credit) begin
          w_inc       = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (i_flush) begin
          w_pc_nxt  = zap_word_align(i_flush_pc);
          w_load_en = 1'b1;
          if (w_ack_any) begin
            w_discard   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            // Bus cycle cannot be abandoned; hold the old address on the bus.
            w_drain_adr_nxt = r_pc;
            w_state_nxt     = DRAIN;
          end
        end else if (w_ack_any) begin
          w_rsp_take = 1'b1;
          w_pc_nxt   = r_pc + ZAP_WORD_BYTES;
          if (w_has_credit) begin
            w_inc       = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_flush) begin
          w_pc_nxt  = zap_word_align(i_flush_pc);
          w_load_en = 1'b1;
        end
        if (w_ack_any) begin
          w_discard   = 1'b1;
          w_load_en   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pc        <= LP_RST_PC;
      r_drain_adr <= LP_RST_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drain_adr <= w_drain_adr_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_opc   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_valid <= w_rsp_take;
      if (w_rsp_take) begin
        r_instr <= i_wb_err ? '0 : i_wb_dat;
        r_opc   <= r_pc;
        r_abort <= i_wb_err;
      end
    end
  end

  assign o_wb_stb = (r_state == REQ) || (r_state == DRAIN);
  assign o_wb_cyc = o_wb_stb;
  assign o_wb_adr = (r_state == DRAIN) ? r_drain_adr : r_pc;
  assign o_wb_sel = ZAP_SEL_ALL;
  assign o_wb_we  = 1'b0;

  assign o_valid  = r_valid;
  assign o_instr  = r_instr;
  assign o_pc     = r_opc;
  assign o_abort  = r_abort;

`ifdef ZAP_PREFETCH_PERF_EN
  logic [15:0] r_discard_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_discard_cnt <= '0;
    end else if (w_discard && (r_discard_cnt != '1)) begin
      r_discard_cnt <= r_discard_cnt + 16'd1;
    end
  end

  assign o_discard_cnt = r_discard_cnt;
`else
  logic w_unused_discard;
  assign w_unused_discard = w_discard;
`endif

endmodule
